// File: rtl/hash_nonce_search.sv
// Nonce-search engine: hashes {block, nonce} for nonces NONCE_START..NONCE_MAX and
// reports the first nonce whose leading CHECK_BYTES hash bytes are all below target.
module hash_nonce_search #(
  parameter int          UNROLL      = 1,
  parameter int          CHECK_BYTES = 2,
  parameter logic [31:0] NONCE_MAX   = 32'hFFFF_FFFF,
  parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        start,
  input  logic        abort,
  input  logic [95:0] block_in,
  input  logic [7:0]  target,
  output logic        busy,
  output logic        fin,
  output logic        found,
  output logic [31:0] nonce_valido_out,
  output logic [23:0] bounty_out
);

  localparam logic [4:0]  LAST_RND  = 5'(32 - UNROLL);
  localparam logic [23:0] HASH_INIT = 24'h01_89_FE;

  typedef enum logic [2:0] {IDLE, LOAD, HASH, CHECK, DONE} state_t;

  state_t      state;
  logic [95:0] blk;
  logic [7:0]  tgt;
  logic [31:0] nonce;
  logic [23:0] hsh;
  logic [4:0]  rnd;
  logic [23:0] hsh_next;
  logic [4:0]  idx;
  logic        hit;

  // Message byte j of the 16-byte schedule: 12 block bytes then 4 nonce bytes, MSB first.
  function automatic logic [7:0] msg_byte(input logic [95:0] b, input logic [31:0] n,
                                          input logic [3:0] j);
    logic [127:0] m;
    m = {b, n};
    return m[127 - 8 * int'(j) -: 8];
  endfunction

  function automatic logic [23:0] hash_round(input logic [23:0] s, input logic [7:0] w,
                                             input logic [4:0] i);
    logic [7:0] a, b, c, k;
    {a, b, c} = s;
    k = i[4] ? 8'hA1 : 8'h99;
    return {b ^ c, {c[3:0], c[7:4]} + w, a ^ k ^ {b[6:0], b[7]}};
  endfunction

  always_comb begin
    hsh_next = hsh;
    idx      = rnd;
    for (int u = 0; u < UNROLL; u++) begin
      idx      = rnd + 5'(u);
      hsh_next = hash_round(hsh_next, msg_byte(blk, nonce, idx[3:0]), idx);
    end
  end

  always_comb begin
    hit = hsh[23:16] < tgt;
    if (CHECK_BYTES >= 2) hit = hit && (hsh[15:8] < tgt);
    if (CHECK_BYTES >= 3) hit = hit && (hsh[7:0] < tgt);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state            <= IDLE;
      blk              <= '0;
      tgt              <= '0;
      nonce            <= '0;
      hsh              <= '0;
      rnd              <= '0;
      busy             <= 1'b0;
      fin              <= 1'b0;
      found            <= 1'b0;
      nonce_valido_out <= '0;
      bounty_out       <= '0;
    end else begin
      fin <= 1'b0;
      // Abort wins over everything else; results already latched are left untouched.
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            blk              <= block_in;
            tgt              <= target;
            nonce            <= NONCE_START;
            found            <= 1'b0;
            nonce_valido_out <= '0;
            bounty_out       <= '0;
            busy             <= 1'b1;
            state            <= LOAD;
          end
          LOAD: begin
            hsh   <= HASH_INIT;
            rnd   <= '0;
            state <= HASH;
          end
          HASH: begin
            hsh <= hsh_next;
            rnd <= rnd + 5'(UNROLL);
            if (rnd == LAST_RND) state <= CHECK;
          end
          CHECK: begin
            if (hit) begin
              found            <= 1'b1;
              nonce_valido_out <= nonce;
              bounty_out       <= hsh;
              busy             <= 1'b0;
              fin              <= 1'b1;
              state            <= DONE;
            end else if (nonce == NONCE_MAX) begin
              // Stop here rather than incrementing, so the counter never wraps.
              busy  <= 1'b0;
              fin   <= 1'b1;
              state <= DONE;
            end else begin
              nonce <= nonce + 32'd1;
              state <= LOAD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hash_nonce_search.sv
// Scoreboard bench for hash_nonce_search: six instances with different parameters share one
// clock and reset; expectations are queued at start and checked whenever a fin pulse appears.
module tb_hash_nonce_search;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        start1, abort1, start_u, start6;
  logic [95:0] block_in;
  logic [7:0]  target;
  logic [5:0]  busy_v, fin_v, found_v;
  logic [31:0] nonce_a [6];
  logic [23:0] bounty_a [6];
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hash_nonce_search #(.UNROLL(1), .CHECK_BYTES(2), .NONCE_MAX(32'd15)) d1 (
    .clk(clk), .reset_L(reset_L), .start(start1), .abort(abort1), .block_in(block_in),
    .target(target), .busy(busy_v[0]), .fin(fin_v[0]), .found(found_v[0]),
    .nonce_valido_out(nonce_a[0]), .bounty_out(bounty_a[0]));
  hash_nonce_search #(.UNROLL(1), .CHECK_BYTES(1)) u1 (
    .clk(clk), .reset_L(reset_L), .start(start_u), .abort(1'b0), .block_in(block_in),
    .target(target), .busy(busy_v[1]), .fin(fin_v[1]), .found(found_v[1]),
    .nonce_valido_out(nonce_a[1]), .bounty_out(bounty_a[1]));
  hash_nonce_search #(.UNROLL(2), .CHECK_BYTES(1)) u2 (
    .clk(clk), .reset_L(reset_L), .start(start_u), .abort(1'b0), .block_in(block_in),
    .target(target), .busy(busy_v[2]), .fin(fin_v[2]), .found(found_v[2]),
    .nonce_valido_out(nonce_a[2]), .bounty_out(bounty_a[2]));
  hash_nonce_search #(.UNROLL(4), .CHECK_BYTES(1)) u4 (
    .clk(clk), .reset_L(reset_L), .start(start_u), .abort(1'b0), .block_in(block_in),
    .target(target), .busy(busy_v[3]), .fin(fin_v[3]), .found(found_v[3]),
    .nonce_valido_out(nonce_a[3]), .bounty_out(bounty_a[3]));
  hash_nonce_search #(.UNROLL(8), .CHECK_BYTES(1)) u8 (
    .clk(clk), .reset_L(reset_L), .start(start_u), .abort(1'b0), .block_in(block_in),
    .target(target), .busy(busy_v[4]), .fin(fin_v[4]), .found(found_v[4]),
    .nonce_valido_out(nonce_a[4]), .bounty_out(bounty_a[4]));
  hash_nonce_search #(.UNROLL(8), .CHECK_BYTES(3), .NONCE_MAX(32'hFFFF_FFFF),
                      .NONCE_START(32'hFFFF_FFFE)) d6 (
    .clk(clk), .reset_L(reset_L), .start(start6), .abort(1'b0), .block_in(block_in),
    .target(target), .busy(busy_v[5]), .fin(fin_v[5]), .found(found_v[5]),
    .nonce_valido_out(nonce_a[5]), .bounty_out(bounty_a[5]));

  typedef struct {
    int          id;
    int          fin_cyc;
    logic        found;
    logic [31:0] nonce;
    logic [23:0] bounty;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference hash written directly from the round equations.
  function automatic logic [23:0] ref_hash(input logic [95:0] blk, input logic [31:0] n);
    logic [7:0] w [16];
    logic [7:0] a, b, c, na, nb, nc, k;
    for (int j = 0; j < 12; j++) w[j] = blk[95 - 8 * j -: 8];
    for (int j = 0; j < 4; j++) w[12 + j] = n[31 - 8 * j -: 8];
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      k  = (i < 16) ? 8'h99 : 8'hA1;
      na = b ^ c;
      nb = {c[3:0], c[7:4]} + w[i % 16];
      nc = a ^ k ^ {b[6:0], b[7]};
      a = na; b = nb; c = nc;
    end
    return {a, b, c};
  endfunction

  function automatic logic ref_ok(input logic [23:0] h, input logic [7:0] t, input int cb);
    logic ok;
    ok = h[23:16] < t;
    if (cb >= 2) ok = ok && (h[15:8] < t);
    if (cb >= 3) ok = ok && (h[7:0] < t);
    return ok;
  endfunction

  task automatic ref_search(input logic [95:0] blk, input logic [7:0] tgt, input int cb,
                            input logic [31:0] ns, input logic [31:0] nm,
                            output logic fnd, output logic [31:0] non,
                            output logic [23:0] bty, output int tries);
    logic [23:0] h;
    fnd = 1'b0; non = '0; bty = '0; tries = 0;
    for (longint n = longint'(ns); n <= longint'(nm) && tries < 4096; n++) begin
      h = ref_hash(blk, 32'(n));
      tries++;
      if (ref_ok(h, tgt, cb)) begin
        fnd = 1'b1; non = 32'(n); bty = h;
        break;
      end
    end
  endtask

  task automatic push_exp(input int id, input int base, input logic [95:0] blk,
                          input logic [7:0] tgt, input int cb, input int unroll,
                          input logic [31:0] ns, input logic [31:0] nm);
    exp_t e;
    int   tries;
    ref_search(blk, tgt, cb, ns, nm, e.found, e.nonce, e.bounty, tries);
    e.id      = id;
    e.fin_cyc = base + tries * (32 / unroll + 2) + 1;
    sb.push_back(e);
  endtask

  function automatic int pending(input int id);
    int p = 0;
    foreach (sb[j]) if (sb[j].id == id) p++;
    return p;
  endfunction

  // Monitor: every fin pulse must match the oldest queued expectation for that instance.
  int   mi;
  exp_t me;
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (fin_v[i] === 1'b1) begin
        mi = -1;
        foreach (sb[j]) if (mi < 0 && sb[j].id == i) mi = j;
        if (mi < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fin dut%0d: fin=1 at cycle %0d, required no fin", i, cyc);
        end else begin
          me = sb[mi];
          sb.delete(mi);
          check($sformatf("fin_cycle dut%0d", i), 32'(cyc), 32'(me.fin_cyc));
          check($sformatf("found dut%0d", i), 32'(found_v[i]), 32'(me.found));
          check($sformatf("nonce dut%0d", i), nonce_a[i], me.nonce);
          check($sformatf("bounty dut%0d", i), 32'(bounty_a[i]), 32'(me.bounty));
        end
      end
    end
  end

  task automatic wait_done(input int id, input int budget);
    int k = 0;
    while (pending(id) > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (pending(id) > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: %0d results outstanding, required 0", id, pending(id));
      for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].id == id) sb.delete(j);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  localparam logic [95:0] BLK_A = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam logic [95:0] BLK_B = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
  localparam logic [95:0] BLK_C = 96'h5A5A_A5A5_0F0F_F0F0_1357_9BDF;

  int          base;
  logic        rf;
  logic [31:0] rn;
  logic [23:0] rb;
  int          rt;

  initial begin
    reset_L = 1'b0; start1 = 1'b0; abort1 = 1'b0; start_u = 1'b0; start6 = 1'b0;
    block_in = BLK_A; target = 8'h00;
    repeat (3) @(negedge clk);
    start1 = 1'b1;            // start coinciding with reset must be ignored
    @(negedge clk);
    reset_L = 1'b1; start1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("reset_busy dut%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset_found dut%0d", i), 32'(found_v[i]), 32'd0);
      check($sformatf("reset_nonce dut%0d", i), nonce_a[i], 32'd0);
      check($sformatf("reset_bounty dut%0d", i), 32'(bounty_a[i]), 32'd0);
    end

    // Exhaustive sweep of 16 nonces with an unreachable target; a stray start mid-search.
    block_in = BLK_A; target = 8'h00;
    start1 = 1'b1; base = cyc;
    push_exp(0, base, BLK_A, 8'h00, 2, 1, 32'd0, 32'd15);
    @(negedge clk);
    start1 = 1'b0;
    check("busy_cycle1", 32'(busy_v[0]), 32'd1);
    wait_until(base + 100);
    start1 = 1'b1; target = 8'hFF;
    @(negedge clk);
    start1 = 1'b0;
    wait_until(base + 544);
    check("busy_last_check", 32'(busy_v[0]), 32'd1);
    wait_done(0, 700);
    @(negedge clk);
    check("busy_after_fin", 32'(busy_v[0]), 32'd0);

    // Same block and target across every unroll factor.
    block_in = BLK_B; target = 8'hFF;
    start_u = 1'b1; base = cyc;
    push_exp(1, base, BLK_B, 8'hFF, 1, 1, 32'd0, 32'hFFFF_FFFF);
    push_exp(2, base, BLK_B, 8'hFF, 1, 2, 32'd0, 32'hFFFF_FFFF);
    push_exp(3, base, BLK_B, 8'hFF, 1, 4, 32'd0, 32'hFFFF_FFFF);
    push_exp(4, base, BLK_B, 8'hFF, 1, 8, 32'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    start_u = 1'b0;
    block_in = BLK_A; target = 8'h00;   // late input changes must not matter
    for (int i = 1; i <= 4; i++) wait_done(i, 3000);

    // A found result, then abort while idle must leave it intact.
    block_in = BLK_C; target = 8'hFF;
    start1 = 1'b1; base = cyc;
    push_exp(0, base, BLK_C, 8'hFF, 2, 1, 32'd0, 32'd15);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(0, 700);
    ref_search(BLK_C, 8'hFF, 2, 32'd0, 32'd15, rf, rn, rb, rt);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    @(negedge clk);
    check("idle_abort_found", 32'(found_v[0]), 32'(rf));
    check("idle_abort_nonce", nonce_a[0], rn);
    check("idle_abort_bounty", 32'(bounty_a[0]), 32'(rb));

    // Abort at cycle 40 of a long search: no fin, outputs stay as cleared by the start.
    block_in = BLK_A; target = 8'h00;
    start1 = 1'b1; base = cyc;
    @(negedge clk);
    start1 = 1'b0;
    wait_until(base + 40);
    check("busy_before_abort", 32'(busy_v[0]), 32'd1);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("busy_after_abort", 32'(busy_v[0]), 32'd0);
    check("abort_found", 32'(found_v[0]), 32'd0);
    check("abort_nonce", nonce_a[0], 32'd0);
    repeat (600) @(negedge clk);
    block_in = BLK_C; target = 8'hFF;
    start1 = 1'b1; base = cyc;
    push_exp(0, base, BLK_C, 8'hFF, 2, 1, 32'd0, 32'd15);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(0, 700);

    // Reset pulse mid-HASH; a start while busy before it is ignored.
    block_in = BLK_A; target = 8'h00;
    start1 = 1'b1; base = cyc;
    @(negedge clk);
    start1 = 1'b0;
    wait_until(base + 5);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_until(base + 10);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_found_u1", 32'(found_v[1]), 32'd0);
    check("rst_nonce_u1", nonce_a[1], 32'd0);
    check("rst_bounty_u1", 32'(bounty_a[1]), 32'd0);
    repeat (600) @(negedge clk);

    // Search at the top of the nonce space must stop at FFFFFFFF without wrapping.
    block_in = BLK_B; target = 8'h00;
    start6 = 1'b1; base = cyc;
    push_exp(5, base, BLK_B, 8'h00, 3, 8, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    @(negedge clk);
    start6 = 1'b0;
    wait_done(5, 100);
    repeat (20) @(negedge clk);
    check("no_wrap_busy", 32'(busy_v[5]), 32'd0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expectations: %0d outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
